// File: rtl/rgb_blink_decoder.sv
// rgb_blink_decoder: observes the three LED drive lines (bit 2 blue, bit 1 green,
// bit 0 red), recovers the colour code that is blinking, and flags short
// intervals, lines stuck high and active channels blinking out of phase.
module rgb_blink_decoder #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BLINK_FREQ = 60,
  parameter int unsigned TOL_PCT    = 5
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [2:0] led_sense,
  input  logic       clear_err,
  output logic [2:0] color_code,
  output logic       code_update,
  output logic [2:0] err_short,
  output logic [2:0] stuck_hi,
  output logic       err_phase
);

  localparam int unsigned HALF = CLK_FREQ / (2 * BLINK_FREQ);
  localparam int unsigned TOL  = HALF * TOL_PCT / 100;
  localparam int unsigned LO   = HALF - TOL;
  localparam int unsigned HI   = HALF + TOL;
  localparam int unsigned CW   = $clog2(HI + 2);

  localparam logic [CW-1:0] LO_V  = CW'(LO);
  localparam logic [CW-1:0] HI_V  = CW'(HI);
  localparam logic [CW-1:0] SAT_V = CW'(HI + 1);
  localparam logic [CW-1:0] ONE_V = CW'(1);

  logic [2:0]          sync1, sync2, prev, edge_det;
  logic [2:0][CW-1:0]  cnt, cnt_nxt;
  logic [2:0]          have_edge, have_nxt;
  logic [2:0][1:0]     good, good_nxt;
  logic [2:0]          short_set, stuck_set, active;
  logic [1:0]          ph_cnt, ph_nxt;
  logic                multi, disagree;

  // Two-flop synchronizer per line plus the previous-level register for edge detection.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= led_sense;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_det = sync2 ^ prev;

  // Per-channel interval measurement and qualification; an edge takes priority over timeout.
  always_comb begin
    cnt_nxt   = cnt;
    have_nxt  = have_edge;
    good_nxt  = good;
    short_set = '0;
    stuck_set = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (edge_det[i]) begin
        cnt_nxt[i] = ONE_V;
        if (!have_edge[i]) begin
          have_nxt[i] = 1'b1;
        end else if (cnt[i] < LO_V) begin
          good_nxt[i]  = 2'd0;
          short_set[i] = 1'b1;
        end else if (cnt[i] <= HI_V) begin
          good_nxt[i] = (good[i] == 2'd2) ? 2'd2 : good[i] + 2'd1;
        end
      end else begin
        if (cnt[i] != SAT_V) begin
          cnt_nxt[i] = cnt[i] + ONE_V;
        end
        // Fires once: the counter moves past HI on the same cycle and saturates there.
        if (cnt[i] == HI_V) begin
          good_nxt[i]  = 2'd0;
          have_nxt[i]  = 1'b0;
          stuck_set[i] = sync2[i];
        end
      end
    end
  end

  // Active channels and the phase-disagreement run length.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      active[i] = (good[i] == 2'd2);
    end
    multi    = (active[0] & active[1]) | (active[0] & active[2]) | (active[1] & active[2]);
    disagree = (|(active & sync2)) & (|(active & ~sync2));
    ph_nxt   = '0;
    if (multi && disagree) begin
      ph_nxt = (ph_cnt == 2'd3) ? 2'd3 : ph_cnt + 2'd1;
    end
  end

  // Channel state, output code and sticky error registers; a set beats a simultaneous clear.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt         <= '0;
      have_edge   <= '0;
      good        <= '0;
      ph_cnt      <= '0;
      color_code  <= '0;
      code_update <= 1'b0;
      err_short   <= '0;
      stuck_hi    <= '0;
      err_phase   <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      have_edge   <= have_nxt;
      good        <= good_nxt;
      ph_cnt      <= ph_nxt;
      color_code  <= active;
      code_update <= (active != color_code);
      err_short   <= (err_short & ~{3{clear_err}}) | short_set;
      stuck_hi    <= (stuck_hi & ~{3{clear_err}}) | stuck_set;
      err_phase   <= (err_phase & ~clear_err) | (ph_cnt == 2'd3);
    end
  end

endmodule
